// File: rtl/ls_cnt_pkg.sv
// Shared constants and helpers for the ls16x counter family.
package ls_cnt_pkg;

  localparam int   CNT_W_DEFAULT = 4;
  localparam logic DIR_UP        = 1'b1;
  localparam logic DIR_DN        = 1'b0;

  // Terminal value: all ones when counting up, zero when counting down.
  function automatic logic [31:0] tc_value(input int width, input logic up);
    return (up == DIR_UP) ? (32'hFFFF_FFFF >> (32 - width)) : 32'd0;
  endfunction

endpackage

// File: rtl/ls_tc_detect.sv
// Terminal-count compare feeding the registered ripple carry/borrow.
// Purely combinational, no flow control; the caller registers the result.
module ls_tc_detect
  import ls_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             UP,
  input  logic             ENT,
  output logic             RCO_d
);

  logic [WIDTH-1:0] tc;

  assign tc    = WIDTH'(tc_value(WIDTH, UP));
  assign RCO_d = ENT && (Q == tc);

endmodule

// File: rtl/ls169a_updown.sv
// Synchronous up/down counter with parallel load and registered ripple carry/borrow.
// Load/count take effect on the sampling edge; RCO lags the terminal Q by one edge.
module ls169a_updown
  import ls_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic rco_d;

  // Compare uses the pre-edge count so the carry timing matches the up-only part.
  ls_tc_detect #(.WIDTH(WIDTH)) u_tc (
    .Q     (Q),
    .UP    (UP),
    .ENT   (ENT),
    .RCO_d (rco_d)
  );

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      Q   <= '0;
      RCO <= 1'b0;
    end else begin
      RCO <= rco_d;
      if (!LOAD_n) begin
        Q <= D;
      end else if (ENP && ENT) begin
        Q <= (UP == DIR_UP) ? (Q + ONE) : (Q - ONE);
      end
    end
  end

endmodule

// File: tb/tb_ls169a_updown.sv
// Bench for ls169a_updown: directed scenarios plus random stimulus against an arithmetic model.
module tb_ls169a_updown;

  logic       CLK = 1'b0;
  logic       CLR_n, LOAD_n, ENP, ENT, UP;
  logic [3:0] D, Q;
  logic       RCO;

  // Two-stage cascade
  logic       c_load_n, c_enp, c_up;
  logic [7:0] c_d;
  logic [3:0] c_q_lo, c_q_hi;
  logic       c_rco_lo, c_rco_hi;

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_q;
  bit m_rco;
  int m_cq;
  bit m_crco_lo, m_crco_hi;

  always #5 CLK = ~CLK;

  ls169a_updown #(.WIDTH(4)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .D(D), .LOAD_n(LOAD_n),
    .ENP(ENP), .ENT(ENT), .UP(UP), .Q(Q), .RCO(RCO)
  );

  ls169a_updown #(.WIDTH(4)) u_lo (
    .CLK(CLK), .CLR_n(CLR_n), .D(c_d[3:0]), .LOAD_n(c_load_n),
    .ENP(c_enp), .ENT(1'b1), .UP(c_up), .Q(c_q_lo), .RCO(c_rco_lo)
  );

  ls169a_updown #(.WIDTH(4)) u_hi (
    .CLK(CLK), .CLR_n(CLR_n), .D(c_d[7:4]), .LOAD_n(c_load_n),
    .ENP(c_enp), .ENT(c_rco_lo), .UP(c_up), .Q(c_q_hi), .RCO(c_rco_hi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int term(input bit up);
    return up ? 15 : 0;
  endfunction

  function automatic int step4(input int v, input bit up);
    return up ? (v + 1) % 16 : (v + 15) % 16;
  endfunction

  task automatic model_edge();
    int lo, hi;
    bit old_lo_rco;
    if (!CLR_n) begin
      m_q = 0; m_rco = 0; m_cq = 0; m_crco_lo = 0; m_crco_hi = 0;
      return;
    end
    m_rco = ENT && (m_q == term(UP));
    if (!LOAD_n)         m_q = D;
    else if (ENP && ENT) m_q = step4(m_q, UP);

    lo = m_cq % 16;
    hi = m_cq / 16;
    old_lo_rco = m_crco_lo;
    m_crco_lo = (lo == term(c_up));
    m_crco_hi = old_lo_rco && (hi == term(c_up));
    if (!c_load_n) begin
      m_cq = c_d;
    end else begin
      if (c_enp)               lo = step4(lo, c_up);
      if (c_enp && old_lo_rco) hi = step4(hi, c_up);
      m_cq = hi * 16 + lo;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Q"},    Q, m_q);
    chk({tag, ".RCO"},  RCO, m_rco);
    chk({tag, ".CQ"},   {c_q_hi, c_q_lo}, m_cq);
    chk({tag, ".CRLO"}, c_rco_lo, m_crco_lo);
    chk({tag, ".CRHI"}, c_rco_hi, m_crco_hi);
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  logic [3:0] exp_seq [4];

  initial begin
    CLR_n = 1'b0; LOAD_n = 1'b1; ENP = 1'b0; ENT = 1'b0; UP = 1'b1; D = 4'h0;
    c_load_n = 1'b1; c_enp = 1'b0; c_up = 1'b0; c_d = 8'h00;
    m_q = 0; m_rco = 0; m_cq = 0; m_crco_lo = 0; m_crco_hi = 0;

    #12;
    chk("reset.Q", Q, 4'h0);
    chk("reset.RCO", RCO, 1'b0);
    CLR_n = 1'b1;

    // Load A, then force RCO high and hit reset mid-cycle
    LOAD_n = 1'b0; D = 4'hA;
    tick("loadA");
    chk("loadA.val", Q, 4'hA);
    D = 4'hF; ENT = 1'b1;
    tick("loadF");
    LOAD_n = 1'b1;
    tick("holdF");
    chk("holdF.RCO", RCO, 1'b1);
    #2;
    CLR_n = 1'b0;
    #1;
    m_q = 0; m_rco = 0; m_cq = 0; m_crco_lo = 0; m_crco_hi = 0;
    chk("async_clr.Q", Q, 4'h0);
    chk("async_clr.RCO", RCO, 1'b0);
    @(negedge CLK);
    CLR_n = 1'b1;

    // Up wrap
    LOAD_n = 1'b0; D = 4'hE; ENP = 1'b1; ENT = 1'b1; UP = 1'b1;
    tick("upw.load");
    LOAD_n = 1'b1;
    tick("upw.1"); chk("upw.F", Q, 4'hF); chk("upw.rco0", RCO, 1'b0);
    tick("upw.2"); chk("upw.0", Q, 4'h0); chk("upw.rco1", RCO, 1'b1);
    tick("upw.3"); chk("upw.1v", Q, 4'h1); chk("upw.rco2", RCO, 1'b0);

    // Down wrap
    LOAD_n = 1'b0; D = 4'h1; UP = 1'b0;
    tick("dnw.load");
    LOAD_n = 1'b1;
    tick("dnw.1"); chk("dnw.0", Q, 4'h0); chk("dnw.rco0", RCO, 1'b0);
    tick("dnw.2"); chk("dnw.F", Q, 4'hF); chk("dnw.rco1", RCO, 1'b1);
    tick("dnw.3"); chk("dnw.E", Q, 4'hE); chk("dnw.rco2", RCO, 1'b0);

    // Gating: ENP low holds, ENT alone drives RCO
    LOAD_n = 1'b0; D = 4'hF; UP = 1'b1;
    tick("gate.load");
    LOAD_n = 1'b1; ENP = 1'b0; ENT = 1'b1;
    tick("gate.enp0"); chk("gate.holdQ", Q, 4'hF); chk("gate.rco_hi", RCO, 1'b1);
    ENT = 1'b0;
    tick("gate.ent0"); chk("gate.holdQ2", Q, 4'hF); chk("gate.rco_lo", RCO, 1'b0);

    // Load beats count, then direction toggles every edge
    LOAD_n = 1'b0; D = 4'h5; ENP = 1'b1; ENT = 1'b1; UP = 1'b1;
    tick("prio.load"); chk("prio.noinc", Q, 4'h5);
    LOAD_n = 1'b1;
    exp_seq[0] = 4'h6; exp_seq[1] = 4'h5; exp_seq[2] = 4'h6; exp_seq[3] = 4'h5;
    for (int i = 0; i < 4; i++) begin
      UP = (i % 2 == 0);
      tick("dir");
      chk("dir.seq", Q, exp_seq[i]);
    end

    // Cascade down-count from 0x10
    c_load_n = 1'b0; c_d = 8'h10; c_up = 1'b0; c_enp = 1'b1;
    tick("casc.load"); chk("casc.10", {c_q_hi, c_q_lo}, 8'h10);
    c_load_n = 1'b1;
    for (int i = 0; i < 6; i++) tick("casc.cnt");

    // Random phase
    for (int i = 0; i < 600; i++) begin
      LOAD_n   = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      D        = 4'($urandom);
      ENP      = ($urandom_range(0, 3) != 0);
      ENT      = ($urandom_range(0, 3) != 0);
      UP       = 1'($urandom);
      c_load_n = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
      c_d      = 8'($urandom);
      c_enp    = ($urandom_range(0, 3) != 0);
      c_up     = ($urandom_range(0, 7) == 0) ? ~c_up : c_up;
      if ($urandom_range(0, 59) == 0) begin
        CLR_n = 1'b0;
        #1;
        m_q = 0; m_rco = 0; m_cq = 0; m_crco_lo = 0; m_crco_hi = 0;
        check_all("rnd.clr");
        @(negedge CLK);
        CLR_n = 1'b1;
      end
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
